ahb_bus_arbiter: RTL and testbench
==================================

AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of AHB requesters; fixed at 4 in this revision.
REQ-002 SHALL have parameter MAX_TENURE, default 8, number of hready-qualified cycles an unlocked owner may hold the bus while others wait; legal range 1-255.
REQ-003 SHALL have port hclk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port hresetn, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port hbusreq, input, 4, per-master bus request; bit i belongs to master i.
REQ-006 SHALL have port hlock, input, 4, per-master locked-transfer request; only meaningful together with the same hbusreq bit.
REQ-007 SHALL have port hready, input, 1, bridge transfer-complete indication (bridge hreadyout); every handover is qualified by it.
REQ-008 SHALL have port hgrant, output, 4, one-hot (or all-zero) grant to the masters.
REQ-009 SHALL have port hmaster, output, 2, index of the current or most recent owner; drives the address/data mux in front of the bridge.
REQ-010 SHALL have port hmastlock, output, 1, asserted while the current owner holds a locked tenure.

Function
REQ-011 SHALL implement a two-state FSM: ARB_IDLE (no owner, hgrant=0) and ARB_OWN (exactly one hgrant bit high).
REQ-012 SHALL register all outputs; a grant decision made in cycle N appears on hgrant/hmaster/hmastlock in cycle N+1.
REQ-013 In ARB_IDLE, with any hbusreq bit high, SHALL select a winner, go to ARB_OWN and grant on the next edge, without waiting for hready.
REQ-014 Winner selection SHALL be round-robin: search starts at index (last_owner+1) mod 4 and wraps; the first requesting index wins.
REQ-015 In ARB_OWN, re-arbitration SHALL happen only in a cycle with hready=1.
REQ-016 Re-arbitration SHALL happen when the owner's hbusreq=0 and hlock=0, or when tenure=MAX_TENURE, hlock[owner]=0 and some other hbusreq bit is high.
REQ-017 On re-arbitration with no other request pending, SHALL go to ARB_IDLE: hgrant=0, hmaster holds its last value, hmastlock=0.
REQ-018 On re-arbitration with requests pending, SHALL go directly to ARB_OWN with the new round-robin winner; the previous owner is eligible only if no other master requests.
REQ-019 Tenure counter, 8 bits: SHALL clear to 0 on every new grant, increment on each hready=1 cycle in ARB_OWN, and saturate at MAX_TENURE.
REQ-020 While hlock[owner]=1, SHALL keep ownership regardless of tenure or other requests; hmastlock SHALL follow hlock[owner] with one-cycle latency.
REQ-021 If the owner drops hbusreq while hready=0, SHALL hold the grant until the first hready=1 cycle.
REQ-022 If hlock[i]=1 while hbusreq[i]=0, SHALL treat that master as not requesting.
REQ-023 SHALL never assert more than one hgrant bit; hmaster SHALL equal the index of the set hgrant bit whenever one is set.

Reset
REQ-024 When hresetn=0 at a rising edge: state=ARB_IDLE, hgrant=4'b0000, hmaster=2'b00, hmastlock=0, tenure=0, last_owner=3 (master 0 has first priority after reset).
REQ-025 Reset asserted mid-tenure SHALL drop the grant at that edge regardless of hready or hlock.
REQ-026 In the first cycle after hresetn rises, SHALL evaluate hbusreq normally.

Verification
REQ-027 Out of reset, hbusreq=4'b1010, hready=1 -> hgrant=4'b0010, hmaster=1 on the next cycle.
REQ-028 Master 1 owns, all four request continuously, hlock=0, hready=1, MAX_TENURE=8 -> grant sequence 1,2,3,0,1, each tenure exactly 9 cycles (8 increments plus the switch cycle).
REQ-029 Master 2 owns with hlock[2]=1 for 20 cycles while master 0 requests -> hgrant stays 4'b0100 and hmastlock=1 throughout; master 0 is granted one cycle after the first hready=1 cycle following hlock[2] and hbusreq[2] both falling.
REQ-030 Owner 3 drops hbusreq while hready=0 for 3 cycles, master 1 requesting -> hgrant=4'b1000 held for those 3 cycles, then 4'b0010 one cycle after hready=1.
REQ-031 Master 0 owns, no other request, hbusreq[0] falls with hready=1 -> next cycle hgrant=0, hmaster=0, hmastlock=0, state ARB_IDLE.
REQ-032 hresetn=0 for one cycle during a locked tenure of master 1 -> all outputs at reset values on the following cycle; a bench assertion checks the one-hot property on every cycle.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter for four masters in front of a single bridge.
// All outputs are registered: a decision made this cycle is visible next cycle.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_TENURE  = 8
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic [3:0] hbusreq,
    input  logic [3:0] hlock,
    input  logic       hready,
    output logic [3:0] hgrant,
    output logic [1:0] hmaster,
    output logic       hmastlock
);

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_state_e;

    localparam logic [7:0] TENURE_MAX = 8'(MAX_TENURE);

    arb_state_e state_q;
    logic [3:0] hgrant_q;
    logic [1:0] hmaster_q;
    logic [1:0] last_owner_q;
    logic       hmastlock_q;
    logic [7:0] tenure_q;

    logic [1:0] winner_d;
    logic       owner_req;
    logic       owner_lock;
    logic       others_req;
    logic       release_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        winner_d = last_owner_q;
        // Search downward from the farthest index so the nearest requester after last_owner wins.
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (hbusreq[2'(int'(last_owner_q) + k)]) begin
                winner_d = 2'(int'(last_owner_q) + k);
            end
        end

        // hmaster_q is the owner index whenever state_q is ARB_OWN.
        owner_req  = hbusreq[hmaster_q];
        owner_lock = hlock[hmaster_q];
        others_req = |(hbusreq & ~hgrant_q);
        release_d  = hready && ((!owner_req && !owner_lock) ||
                                (tenure_q == TENURE_MAX && !owner_lock && others_req));
    end

    always_ff @(posedge hclk) begin
        // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
        if (!hresetn) begin
            state_q      <= ARB_IDLE;
            hgrant_q     <= 4'b0000;
            hmaster_q    <= 2'd0;
            hmastlock_q  <= 1'b0;
            tenure_q     <= 8'd0;
            last_owner_q <= 2'd3;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (|hbusreq) begin
                        state_q      <= ARB_OWN;
                        hgrant_q     <= 4'b0001 << winner_d;
                        hmaster_q    <= winner_d;
                        last_owner_q <= winner_d;
                        hmastlock_q  <= hlock[winner_d];
                        tenure_q     <= 8'd0;
                    end
                end
                ARB_OWN: begin
                    if (release_d) begin
                        if (|hbusreq) begin
                            hgrant_q     <= 4'b0001 << winner_d;
                            hmaster_q    <= winner_d;
                            last_owner_q <= winner_d;
                            hmastlock_q  <= hlock[winner_d];
                            tenure_q     <= 8'd0;
                        end else begin
                            // hmaster keeps pointing at the last owner for the bridge mux.
                            state_q     <= ARB_IDLE;
                            hgrant_q    <= 4'b0000;
                            hmastlock_q <= 1'b0;
                            tenure_q    <= 8'd0;
                        end
                    end else begin
                        hmastlock_q <= owner_lock;
                        if (hready && tenure_q != TENURE_MAX) begin
                            tenure_q <= tenure_q + 8'd1;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_ahb_bus_arbiter;

    localparam int MAXT = 8;

    logic       hclk = 1'b0;
    logic       hresetn;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: owner index (-1 = nobody), round-robin pointer, tenure.
    int m_owner  = -1;
    int m_last   = 3;
    int m_tenure = 0;
    int m_master = 0;
    bit m_lock   = 1'b0;

    ahb_bus_arbiter #(.NUM_MASTERS(4), .MAX_TENURE(MAXT)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (req[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w, input logic [3:0] lock);
        m_owner  = w;
        m_last   = w;
        m_master = w;
        m_tenure = 0;
        m_lock   = lock[w];
    endtask

    task automatic model_update(input logic [3:0] req, input logic [3:0] lock,
                                input logic rdy, input logic rstn);
        int  o;
        bit  free_bus;
        bit  expired;
        if (!rstn) begin
            m_owner = -1; m_last = 3; m_tenure = 0; m_master = 0; m_lock = 1'b0;
        end else if (m_owner < 0) begin
            if (req != 4'b0) model_grant(rr_pick(req, m_last), lock);
        end else begin
            o        = m_owner;
            free_bus = !req[o] && !lock[o];
            expired  = (m_tenure == MAXT) && !lock[o] && ((req & ~(4'b1 << o)) != 4'b0);
            if (rdy && (free_bus || expired)) begin
                if (req == 4'b0) begin
                    m_owner = -1; m_lock = 1'b0; m_tenure = 0;
                end else begin
                    model_grant(rr_pick(req, o), lock);
                end
            end else begin
                m_lock = lock[o];
                if (rdy && m_tenure < MAXT) m_tenure++;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare mid-cycle.
    task automatic step(input logic [3:0] req, input logic [3:0] lock,
                        input logic rdy, input logic rstn);
        logic [3:0] exp_grant;
        hbusreq = req;
        hlock   = lock;
        hready  = rdy;
        hresetn = rstn;
        @(posedge hclk);
        model_update(req, lock, rdy, rstn);
        @(negedge hclk);
        exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("model_hgrant", 8'(hgrant), 8'(exp_grant));
        check("model_hmaster", 8'(hmaster), 8'(m_master));
        check("model_hmastlock", 8'(hmastlock), 8'(m_lock));
        check("onehot_hgrant", 8'($onehot0(hgrant)), 8'd1);
    endtask

    initial begin
        int         seq [5];
        logic [3:0] r_req;
        logic [3:0] r_lock;
        seq = '{1, 2, 3, 0, 1};

        // Reset state.
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("reset_hgrant", 8'(hgrant), 8'h00);
        check("reset_hmaster", 8'(hmaster), 8'h00);
        check("reset_hmastlock", 8'(hmastlock), 8'h00);

        // First request after reset: masters 1 and 3 ask, master 1 is nearer.
        step(4'b1010, 4'b0000, 1'b1, 1'b1);
        check("first_grant", 8'(hgrant), 8'h02);
        check("first_hmaster", 8'(hmaster), 8'h01);

        // Everyone requesting: tenure expiry rotates 1,2,3,0,1 every 9 cycles.
        for (int k = 1; k <= 36; k++) begin
            step(4'b1111, 4'b0000, 1'b1, 1'b1);
            check("rotation_grant", 8'(hgrant), 8'(4'b0001 << seq[k / 9]));
        end

        // Owner 1 drops with nobody else waiting: bus goes idle, hmaster sticks.
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        check("idle_hgrant", 8'(hgrant), 8'h00);
        check("idle_hmaster", 8'(hmaster), 8'h01);
        check("idle_hmastlock", 8'(hmastlock), 8'h00);

        // Locked tenure of master 2 survives tenure expiry and master 0 waiting.
        step(4'b0100, 4'b0100, 1'b1, 1'b1);
        check("lock_grant", 8'(hgrant), 8'h04);
        check("lock_hmastlock", 8'(hmastlock), 8'h01);
        for (int k = 0; k < 20; k++) begin
            step(4'b0101, 4'b0100, 1'($urandom_range(1)), 1'b1);
            check("lock_hold_grant", 8'(hgrant), 8'h04);
            check("lock_hold_mastlock", 8'(hmastlock), 8'h01);
        end
        step(4'b0001, 4'b0000, 1'b0, 1'b1);
        check("unlock_wait_grant", 8'(hgrant), 8'h04);
        check("unlock_wait_mastlock", 8'(hmastlock), 8'h00);
        step(4'b0001, 4'b0000, 1'b0, 1'b1);
        check("unlock_wait_grant2", 8'(hgrant), 8'h04);
        step(4'b0001, 4'b0000, 1'b1, 1'b1);
        check("unlock_handover", 8'(hgrant), 8'h01);
        check("unlock_hmaster", 8'(hmaster), 8'h00);

        // Master 0 alone releases with hready high.
        step(4'b0001, 4'b0000, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        check("m0_release_grant", 8'(hgrant), 8'h00);
        check("m0_release_hmaster", 8'(hmaster), 8'h00);
        check("m0_release_mastlock", 8'(hmastlock), 8'h00);

        // Owner 3 drops while hready is low: grant is held until hready.
        step(4'b1000, 4'b0000, 1'b1, 1'b1);
        check("m3_grant", 8'(hgrant), 8'h08);
        for (int k = 0; k < 3; k++) begin
            step(4'b0010, 4'b0000, 1'b0, 1'b1);
            check("m3_hold", 8'(hgrant), 8'h08);
        end
        step(4'b0010, 4'b0000, 1'b1, 1'b1);
        check("m3_to_m1", 8'(hgrant), 8'h02);
        check("m3_to_m1_hmaster", 8'(hmaster), 8'h01);

        // Reset in the middle of a locked tenure of master 1.
        step(4'b0010, 4'b0010, 1'b1, 1'b1);
        step(4'b0010, 4'b0010, 1'b0, 1'b1);
        check("m1_locked", 8'(hmastlock), 8'h01);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        check("midreset_grant", 8'(hgrant), 8'h00);
        check("midreset_hmaster", 8'(hmaster), 8'h00);
        check("midreset_mastlock", 8'(hmastlock), 8'h00);
        step(4'b0011, 4'b0000, 1'b1, 1'b1);
        check("post_reset_priority", 8'(hgrant), 8'h01);

        // Randomized traffic with sticky requests and locks.
        r_req  = 4'b0000;
        r_lock = 4'b0000;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(4) == 0) r_req[b] = ~r_req[b];
                if ($urandom_range(12) == 0) r_lock[b] = ~r_lock[b];
            end
            step(r_req, r_lock, 1'($urandom_range(3) != 0), 1'($urandom_range(199) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
